// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port with valid/ready handshake.
// The core drives the request side; memory answers with ready and read data.
interface mips_multicycle_core_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-I subset core, FETCH/DECODE/EXEC/MEM/WB over one memory port.
// Define MIPS_MC_EXC_EN for illegal-instruction traps, EPC and eret.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int          MEM_ADDR_W = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    mips_multicycle_core_if.master         mem,
    output logic                           retire,
    output logic                           halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL,
        OP_JR, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
        OP_J, OP_JAL, OP_ERET, OP_BREAK, OP_ILL
    } op_t;

    state_t state_q, state_d;
    op_t    op_q, op_d, dec_op;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        z_q, z_d;
`ifdef MIPS_MC_EXC_EN
    logic [31:0] epc_q, epc_d;
`endif

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic [31:0] rf_q [32];
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [31:0] alu_res;
    logic [31:0] rs_val, rt_val;
    logic        xfer;

    wire [5:0] opc = ir_q[31:26];
    wire [4:0] rs  = ir_q[25:21];
    wire [4:0] rt  = ir_q[20:16];
    wire [4:0] rd  = ir_q[15:11];
    wire [4:0] sh  = ir_q[10:6];
    wire [5:0] fn  = ir_q[5:0];

    assign xfer   = mem_req_q & mem.mem_ready;
    assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    always_comb begin
        dec_op = OP_ILL;
        case (opc)
            6'h00: begin
                case (fn)
                    6'h00:   dec_op = OP_SLL;
                    6'h02:   dec_op = OP_SRL;
                    6'h08:   dec_op = OP_JR;
                    6'h0D:   dec_op = OP_BREAK;
                    6'h20:   dec_op = OP_ADD;
                    6'h22:   dec_op = OP_SUB;
                    6'h24:   dec_op = OP_AND;
                    6'h25:   dec_op = OP_OR;
                    6'h2A:   dec_op = OP_SLT;
                    default: dec_op = OP_ILL;
                endcase
            end
            6'h02:   dec_op = OP_J;
            6'h03:   dec_op = OP_JAL;
            6'h04:   dec_op = OP_BEQ;
            6'h05:   dec_op = OP_BNE;
            6'h08:   dec_op = OP_ADDI;
            6'h0C:   dec_op = OP_ANDI;
            6'h0D:   dec_op = OP_ORI;
`ifdef MIPS_MC_EXC_EN
            6'h10:   dec_op = (fn == 6'h18) ? OP_ERET : OP_ILL;
`endif
            6'h23:   dec_op = OP_LW;
            6'h2B:   dec_op = OP_SW;
            default: dec_op = OP_ILL;
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        case (op_q)
            OP_ADD:                 alu_res = a_q + b_q;
            OP_SUB, OP_BEQ, OP_BNE: alu_res = a_q - b_q;
            OP_AND:                 alu_res = a_q & b_q;
            OP_OR:                  alu_res = a_q | b_q;
            OP_SLT:                 alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
            OP_SLL:                 alu_res = b_q << sh;
            OP_SRL:                 alu_res = b_q >> sh;
            OP_ADDI, OP_LW, OP_SW:  alu_res = a_q + imm_q;
            OP_ANDI:                alu_res = a_q & imm_q;
            OP_ORI:                 alu_res = a_q | imm_q;
            OP_JAL:                 alu_res = pc_q;
            OP_JR:                  alu_res = a_q;
            default:                alu_res = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            op_q        <= OP_NOP;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            imm_q       <= 32'd0;
            alu_q       <= 32'd0;
            mdr_q       <= 32'd0;
            z_q         <= 1'b0;
`ifdef MIPS_MC_EXC_EN
            epc_q       <= 32'd0;
`endif
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            z_q         <= z_d;
`ifdef MIPS_MC_EXC_EN
            epc_q       <= epc_d;
`endif
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Gated by reset so an abandoned instruction leaves no register side effect.
    always_ff @(posedge clk) begin
        if (!reset && rf_we && rf_wa != 5'd0) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        z_d     = z_q;
`ifdef MIPS_MC_EXC_EN
        epc_d   = epc_q;
`endif
        rf_we   = 1'b0;
        rf_wa   = 5'd0;
        rf_wd   = 32'd0;
        case (state_q)
            S_FETCH: begin
                if (xfer) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                imm_d = (dec_op == OP_ANDI || dec_op == OP_ORI)
                      ? {16'd0, ir_q[15:0]}
                      : {{16{ir_q[15]}}, ir_q[15:0]};
                op_d  = (dec_op == OP_ILL) ? OP_NOP : dec_op;
                if (dec_op == OP_BREAK) begin
                    state_d = S_HALT;
`ifdef MIPS_MC_EXC_EN
                end else if (dec_op == OP_ILL) begin
                    epc_d   = pc_q - 32'd4;
                    pc_d    = EXC_VECTOR;
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d   = alu_res;
                z_d     = (alu_res == 32'd0);
                state_d = S_FETCH;
                case (op_q)
                    OP_BEQ: if (alu_res == 32'd0) pc_d = pc_q + {imm_q[29:0], 2'b00};
                    OP_BNE: if (alu_res != 32'd0) pc_d = pc_q + {imm_q[29:0], 2'b00};
                    OP_J:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                    OP_JAL: begin
                        pc_d  = {pc_q[31:28], ir_q[25:0], 2'b00};
                        rf_we = 1'b1;
                        rf_wa = 5'd31;
                        rf_wd = pc_q;
                    end
                    OP_JR:  pc_d = a_q;
`ifdef MIPS_MC_EXC_EN
                    OP_ERET: pc_d = epc_q;
`endif
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL,
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (xfer) begin
                    if (op_q == OP_SW) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem.mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wa   = (opc == 6'h00) ? rd : rt;
                rf_wd   = (op_q == OP_LW) ? mdr_q : alu_q;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Request fields are registered and launched on the transition into FETCH/MEM.
    always_comb begin
        retire      = (state_q == S_WB)
                    | ((state_q == S_EXEC || state_q == S_MEM) && state_d == S_FETCH);
        halted      = (state_q == S_HALT);
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (xfer) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
        end
        if (state_d == S_FETCH && (state_q != S_FETCH || !mem_req_q)) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {pc_d[MEM_ADDR_W-1:2], 2'b00};
            mem_wdata_d = 32'd0;
        end else if (state_d == S_MEM && state_q != S_MEM) begin
            mem_req_d   = 1'b1;
            mem_we_d    = (op_q == OP_SW);
            mem_addr_d  = {alu_res[MEM_ADDR_W-1:2], 2'b00};
            mem_wdata_d = b_q;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core against a unified memory model
// with programmable wait states and a ready hold for abandoned accesses.
module tb_mips_multicycle_core;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic retire, halted;
    logic load = 1'b0;
    logic hold = 1'b0;
    int   wait_cfg = 0;
    int   cnt = 0;
    int   cyc = 0;
    int   unstable = 0;
    int   stalls = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] img [256];
    logic [31:0] mem [256];
    logic [31:0] rd_log [$];
    int          ret_log [$];

    logic        prev_wait = 1'b0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wd = '0;

    localparam logic [31:0] ALU_EXP [11] = '{
        32'h8, 32'h5, 32'hFFFF_FFFD, 32'h1, 32'h0, 32'h50,
        32'hF, 32'h0000_FF00, 32'h0000_8001, 32'h7, 32'h0
    };

    mips_multicycle_core_if #(.ADDR_W(32)) mif ();

    mips_multicycle_core dut (
        .clk    (clk),
        .reset  (reset),
        .mem    (mif),
        .retire (retire),
        .halted (halted)
    );

    always #5 clk = ~clk;

    assign mif.mem_ready = mif.mem_req && !hold && (cnt >= wait_cfg);
    assign mif.mem_rdata = mem[mif.mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] = img[i];
        end
        if (reset) begin
            rd_log.delete();
            ret_log.delete();
            cnt <= 0;
            unstable <= 0;
            stalls <= 0;
            prev_wait <= 1'b0;
        end else begin
            if (mif.mem_req && mif.mem_ready) begin
                if (mif.mem_we) mem[mif.mem_addr[9:2]] = mif.mem_wdata;
                else rd_log.push_back(mif.mem_addr);
                cnt <= 0;
            end else if (mif.mem_req) begin
                cnt <= cnt + 1;
            end else begin
                cnt <= 0;
            end
            if (retire) ret_log.push_back(cyc);
            if (prev_wait && (!mif.mem_req || mif.mem_we !== p_we ||
                mif.mem_addr !== p_addr || mif.mem_wdata !== p_wd))
                unstable <= unstable + 1;
            if (mif.mem_req && !mif.mem_ready) stalls <= stalls + 1;
            prev_wait <= mif.mem_req && !mif.mem_ready;
            p_we      <= mif.mem_we;
            p_addr    <= mif.mem_addr;
            p_wd      <= mif.mem_wdata;
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic int lat(input int i);
        return (i < ret_log.size()) ? ret_log[i] - ret_log[i-1] : -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reads(input string tag, input int n, input logic [319:0] exp);
        chk({tag, " nreads"}, rd_log.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s rd%0d", tag, i),
                (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF,
                exp[32*(n-1-i) +: 32]);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'd0;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        load  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic start();
        hold_reset();
        reset = 1'b0;
    endtask

    task automatic run(input string tag, input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " halted"}, halted, 1'b1);
    endtask

    task automatic quiet(input string tag);
        int q = 0;
        repeat (5) begin
            @(negedge clk);
            if (mif.mem_req) q++;
        end
        chk({tag, " quiet"}, q, 0);
    endtask

    localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0C, ORI = 6'h0D;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] JJ = 6'h02, JAL = 6'h03;

    initial begin
        logic [31:0] brk;
        brk = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h0D);

        // Test 1: basic add sequence, reset values, halt behaviour
        clear_img();
        img[0] = enc_i(ADDI, 5'd0, 5'd1, 16'd5);
        img[1] = enc_i(ADDI, 5'd0, 5'd2, 16'hFFFD);
        img[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        img[3] = enc_i(SW, 5'd0, 5'd3, 16'h100);
        img[4] = brk;
        hold_reset();
        chk("rst mem_req", mif.mem_req, 1'b0);
        chk("rst mem_we", mif.mem_we, 1'b0);
        chk("rst mem_addr", mif.mem_addr, 32'h0);
        chk("rst mem_wdata", mif.mem_wdata, 32'h0);
        chk("rst retire", retire, 1'b0);
        chk("rst halted", halted, 1'b0);
        reset = 1'b0;
        run("t1", 200);
        chk("t1 add result", mem[64], 32'd2);
        chk("t1 retires", ret_log.size(), 4);
        chk("t1 addi latency", lat(1), 4);
        chk("t1 sw latency", lat(3), 4);
        quiet("t1");

        // ALU coverage: results stored to 0x100.. in order $4..$13, $0
        clear_img();
        img[0]  = enc_i(ADDI, 5'd0, 5'd1, 16'd5);
        img[1]  = enc_i(ADDI, 5'd0, 5'd2, 16'hFFFD);
        img[2]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
        img[3]  = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h24);
        img[4]  = enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h25);
        img[5]  = enc_r(5'd2, 5'd1, 5'd7, 5'd0, 6'h2A);
        img[6]  = enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h2A);
        img[7]  = enc_r(5'd0, 5'd1, 5'd9, 5'd4, 6'h00);
        img[8]  = enc_r(5'd0, 5'd2, 5'd10, 5'd28, 6'h02);
        img[9]  = enc_i(ANDI, 5'd2, 5'd11, 16'hFF00);
        img[10] = enc_i(ORI, 5'd0, 5'd12, 16'h8001);
        img[11] = enc_i(ADDI, 5'd0, 5'd13, 16'd7);
        img[12] = enc_i(ADDI, 5'd0, 5'd0, 16'd7);
        for (int k = 0; k < 11; k++)
            img[13+k] = enc_i(SW, 5'd0, (k < 10) ? 5'(4 + k) : 5'd0, 16'(256 + 4 * k));
        img[24] = brk;
        start();
        run("alu", 500);
        for (int k = 0; k < 11; k++)
            chk($sformatf("alu word%0d", k), mem[64+k], ALU_EXP[k]);

        // Test 2: two wait states per access
        clear_img();
        img[0]   = enc_i(ADDI, 5'd0, 5'd3, 16'd2);
        img[1]   = enc_i(SW, 5'd0, 5'd3, 16'h200);
        img[2]   = enc_i(LW, 5'd0, 5'd4, 16'h200);
        img[3]   = enc_i(SW, 5'd0, 5'd4, 16'h104);
        img[4]   = brk;
        img[128] = 32'h0000_0BAD;
        wait_cfg = 2;
        start();
        run("t2", 400);
        chk("t2 sw data", mem[128], 32'd2);
        chk("t2 lw data", mem[65], 32'd2);
        chk("t2 sw latency", lat(1), 8);
        // 5 base cycles plus two waits on the fetch and two on the load
        chk("t2 lw latency", lat(2), 9);
        chk("t2 stable", unstable, 0);
        chk("t2 stalls seen", stalls > 0, 1'b1);
        wait_cfg = 0;

        // Test 3: beq taken then bne not taken
        clear_img();
        img[0] = enc_i(ADDI, 5'd0, 5'd5, 16'h11);
        img[1] = enc_i(ADDI, 5'd0, 5'd1, 16'd1);
        img[2] = enc_i(BEQ, 5'd1, 5'd1, 16'd2);
        img[3] = enc_i(ADDI, 5'd0, 5'd5, 16'h55);
        img[4] = enc_i(ADDI, 5'd0, 5'd5, 16'h66);
        img[5] = enc_i(BNE, 5'd1, 5'd1, 16'd5);
        img[6] = enc_i(SW, 5'd0, 5'd5, 16'h100);
        img[7] = enc_i(SW, 5'd0, 5'd1, 16'h104);
        img[8] = brk;
        start();
        run("t3", 300);
        chk_reads("t3", 7, {32'h0, 32'h4, 32'h8, 32'h14, 32'h18, 32'h1C, 32'h20});
        chk("t3 skipped", mem[64], 32'h11);
        chk("t3 rt kept", mem[65], 32'h1);
        chk("t3 beq latency", lat(2), 3);
        chk("t3 bne latency", lat(3), 3);

        // Test 4: jal / jr
        clear_img();
        img[0]  = enc_i(ADDI, 5'd0, 5'd1, 16'd1);
        img[4]  = enc_j(JAL, 26'h10);
        img[5]  = enc_i(SW, 5'd0, 5'd1, 16'h104);
        img[6]  = brk;
        img[16] = enc_i(SW, 5'd0, 5'd31, 16'h100);
        img[17] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        start();
        run("t4", 300);
        chk_reads("t4", 9, {32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
                            32'h40, 32'h44, 32'h14, 32'h18});
        chk("t4 link", mem[64], 32'h14);
        chk("t4 return", mem[65], 32'h1);
        chk("t4 jal latency", lat(4), 3);

        // Test 5: reset while a store is stalled
        clear_img();
        img[0]  = enc_i(ADDI, 5'd0, 5'd3, 16'd9);
        img[1]  = enc_i(SW, 5'd0, 5'd3, 16'h100);
        img[2]  = brk;
        img[64] = 32'hDEAD_BEEF;
        wait_cfg = 2;
        start();
        begin
            int n = 0;
            while (!(mif.mem_req && mif.mem_we) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t5 store seen", mif.mem_req && mif.mem_we, 1'b1);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5 held addr", mif.mem_addr, 32'h100);
        reset = 1'b1;
        @(negedge clk);
        chk("t5 req dropped", mif.mem_req, 1'b0);
        chk("t5 mem intact", mem[64], 32'hDEAD_BEEF);
        @(negedge clk);
        hold = 1'b0;
        wait_cfg = 0;
        reset = 1'b0;
        run("t5", 200);
        chk_reads("t5", 3, {32'h0, 32'h4, 32'h8});
        chk("t5 rerun store", mem[64], 32'd9);

        // Test 6: illegal opcode at 0x20
        clear_img();
        img[0]  = enc_j(JJ, 26'h8);
        img[8]  = 32'hFC00_0000;
        img[9]  = brk;
        img[32] = brk;
        start();
        run("t6", 200);
`ifdef MIPS_MC_EXC_EN
        chk_reads("t6", 3, {32'h0, 32'h20, 32'h80});
        chk("t6 retires", ret_log.size(), 1);
        chk("t6 epc", dut.epc_q, 32'h20);
`else
        chk_reads("t6", 3, {32'h0, 32'h20, 32'h24});
        chk("t6 retires", ret_log.size(), 2);
        chk("t6 nop latency", lat(1), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
